// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit 7-segment scanner.
// Each frame snapshots value/dp_in/blank_lz, then lights digits 0..3 in turn.
// Every slot opens with a dark guard interval. Outputs are registered one
// cycle behind the tick/idx counters.
module seg7_scan_driver #(
    parameter int DIGIT_TICKS = 12500,
    parameter int BLANK_TICKS = 250,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig,
    output logic        frame_start
);
    localparam int            TW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] GUARD_END = TW'(BLANK_TICKS);
    // Inactive pin levels; XOR with these applies the pin polarity.
    localparam logic [6:0]    SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_OFF    = SEG_ACT_LOW;
    localparam logic [3:0]    DIG_OFF   = DIG_ACT_LOW ? 4'hF : 4'h0;

    logic [TW-1:0] tick_cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [3:0]    shadow_dp;
    logic          shadow_lz;

    logic          snap;
    logic [15:0]   cur_val;
    logic [3:0]    cur_dp;
    logic          cur_lz;
    logic [3:0]    nib;
    logic          lz_zero;
    logic          blank;
    logic [6:0]    seg_nx;
    logic          dp_nx;
    logic [3:0]    dig_nx;

    // Hex to active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h00;
        case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // The first cycle of the digit0 slot is the snapshot cycle.
    assign snap = enable && (idx == 2'd0) && (tick_cnt == '0);

    // Slot timing: tick_cnt walks through a slot, and idx advances at the end of each slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            idx      <= 2'd0;
        end else if (!enable) begin
            tick_cnt <= '0;
            idx      <= 2'd0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Frame snapshot: a whole frame shows one consistent value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow    <= 16'h0000;
            shadow_dp <= 4'h0;
            shadow_lz <= 1'b0;
        end else if (snap) begin
            shadow    <= value;
            shadow_dp <= dp_in;
            shadow_lz <= blank_lz;
        end
    end

    // Next active-high pattern. The snapshot cycle bypasses the shadow,
    // so the first guard cycle already carries the newly captured digit.
    always_comb begin
        cur_val = snap ? value    : shadow;
        cur_dp  = snap ? dp_in    : shadow_dp;
        cur_lz  = snap ? blank_lz : shadow_lz;
        nib     = 4'h0;
        lz_zero = 1'b0;
        case (idx)
            2'd0: begin nib = cur_val[3:0];   lz_zero = 1'b0;                   end
            2'd1: begin nib = cur_val[7:4];   lz_zero = (cur_val[15:4]  == '0); end
            2'd2: begin nib = cur_val[11:8];  lz_zero = (cur_val[15:8]  == '0); end
            default: begin nib = cur_val[15:12]; lz_zero = (cur_val[15:12] == '0); end
        endcase
        blank  = cur_lz && lz_zero;
        seg_nx = 7'h00;
        dp_nx  = 1'b0;
        dig_nx = 4'h0;
        if (enable && !blank) begin
            seg_nx = hex_to_seg(nib);
            dp_nx  = cur_dp[idx];
            if (tick_cnt >= GUARD_END)
                dig_nx = 4'b0001 << idx;
        end
    end

    // Output register with the pin polarity applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            dig         <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nx ^ SEG_OFF;
            dp          <= dp_nx ^ DP_OFF;
            dig         <= dig_nx ^ DIG_OFF;
            frame_start <= snap;
        end
    end

endmodule
